data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised, byte-addressed data memory with request/response handshake, configurable wait states and
//  byte/half/word(/dword) sized accesses with sign/zero extension. Sits on the core's MEM stage, replacing the
//  word-only single-cycle data memory; flags misaligned, out-of-range and malformed requests instead of corrupting state.
// PARAMETERS
//  W    32  data width in bits; 32 or 64 only; byte lanes L=W/8, offset bits B=log2(L)
//  N    8   log2 of depth in words (2**N words of W bits)
//  LAT  1   wait states between accept and response, 0..7
// PORTS
//  clk          in   1  clock, all logic on rising edge
//  rst          in   1  synchronous active-high reset
//  req_valid    in   1  request present
//  req_ready    out  1  block can accept a request this cycle
//  MemRead      in   1  request is a load
//  MemWrite     in   1  request is a store
//  address      in   W  byte address
//  size         in   2  00 byte, 01 half, 10 word, 11 dword (W=64 only)
//  unsigned_ld  in   1  1: zero-extend load, 0: sign-extend
//  write_data   in   W  store data, right-aligned (bits [8*bytes-1:0] used)
//  resp_valid   out  1  one-cycle response pulse
//  read_data    out  W  load result, extended to W
//  err          out  1  request rejected, valid with resp_valid
// BEHAVIOUR
//  - Reset (synchronous, rst=1 at clk edge): all 2**N words <= 0; req_ready=1, resp_valid=0, read_data=0, err=0,
//    FSM -> IDLE, wait counter=0. Reset mid-operation aborts: pending store NOT written, no response issued.
//  - FSM: IDLE -> (req_valid) latch request, LAT>0 ? WAIT : RESP; WAIT counts LAT cycles -> RESP; RESP -> IDLE.
//  - req_ready=1 only in IDLE; request inputs sampled only on accept (req_valid&&req_ready), ignored otherwise.
//  - Latency: resp_valid high exactly LAT+1 cycles after accept edge, for one cycle; no backpressure.
//    Max throughput one request per LAT+2 cycles.
//  - Word index = address[N+B-1:B]; lane offset = address[B-1:0]; little-endian lanes.
//  - Errors (checked at accept, reported at response; err=1, read_data=0, memory unchanged):
//    misaligned (offset not multiple of access size), address[W-1:N+B] != 0, size=11 with W=32,
//    MemRead and MemWrite both 1.
//  - Neither MemRead nor MemWrite: accepted as no-op, response with err=0, read_data=0.
//  - Store: only addressed byte lanes updated, written on the clock edge that raises resp_valid; read_data=0.
//  - Load: selected bytes shifted to bit 0, extended per unsigned_ld; full-width access ignores unsigned_ld.
//  - read_data/err hold last response value until next response or reset.
//  - Request addressing same word as a just-completed store sees the new data (store done before IDLE).
// CONFIGURATION
//  DATA_MEM_PERF_EN defined: adds outputs rd_cnt, wr_cnt, err_cnt (16 bits each); increment at each response
//    that is a successful load / successful store / error; saturate at 16'hFFFF; cleared by rst.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 rst for 2 cycles, then load word addr 0x40 -> resp_valid at accept+LAT+1, read_data=0, err=0.
//  2 W=32: store word 0x8081_82F3 @0x10; load byte @0x10 signed -> 0xFFFF_FFF3; unsigned @0x13 -> 0x0000_0080;
//    half signed @0x12 -> 0xFFFF_8081.
//  3 store half 0xBEEF @0x22 over word 0x1122_3344 @0x20 -> load word @0x20 = 0xBEEF_3344.
//  4 load half @0x21, word @0x22, MemRead=MemWrite=1, address 2**(N+2) -> each err=1, read_data=0, memory unchanged.
//  5 LAT=3: req_valid held high continuously -> accepts every 5 cycles, req_ready low 4 cycles after each accept;
//    LAT=0 -> resp next cycle, accept every 2.
//  6 accept store 0xDEAD_BEEF @0x30, assert rst in WAIT -> no resp_valid; load @0x30 -> 0; with DATA_MEM_PERF_EN
//    after tests 2-4 counters match issued counts, then rst -> all 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory behind a request/response handshake.
// Each access waits LAT cycles after it is accepted. Accesses can be byte, half,
// word or dword (dword only when W=64), and loads are sign- or zero-extended.
// Misaligned, out-of-range and malformed requests are answered with err=1 and
// leave the memory unchanged.
// Optional feature macro: DATA_MEM_PERF_EN adds saturating counters for loads,
// stores and errors.
module data_mem_ctrl #(
    parameter int W   = 32,
    parameter int N   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [W-1:0] address,
    input  logic [1:0]   size,
    input  logic         unsigned_ld,
    input  logic [W-1:0] write_data,
    output logic         resp_valid,
    output logic [W-1:0] read_data,
    output logic         err
`ifdef DATA_MEM_PERF_EN
    ,
    output logic [15:0]  rd_cnt,
    output logic [15:0]  wr_cnt,
    output logic [15:0]  err_cnt
`endif
);

    localparam int L = W / 8;
    localparam int B = $clog2(L);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_nx;
    logic [2:0]     cnt;
    logic [W-1:0]   mem [2**N];

    logic           accept;
    logic           req_err;
    logic           rd_q, wr_q, err_q, uns_q;
    logic [N-1:0]   idx_q;
    logic [B-1:0]   off_q;
    logic [1:0]     size_q;
    logic [W-1:0]   wdata_q;

    logic [W-1:0]   word, sh, lomask, topbit, ext, wsh;
    logic [7:0]     nbits;
    logic [L-1:0]   bmask, be;
    logic [B-1:0]   ofs_mask;

    assign accept = req_valid && req_ready;

    // Validity of the incoming request, evaluated only at accept
    always_comb begin
        ofs_mask = ~({B{1'b1}} << size);
        req_err  = |(address[B-1:0] & ofs_mask)          // misaligned
                || ((address >> (N + B)) != '0)          // beyond the array
                || ((W == 32) && (size == 2'b11))        // dword on a 32-bit build
                || (MemRead && MemWrite);                // ambiguous direction
    end

    // State register and wait counter; reset abandons any request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == WAIT) ? cnt + 3'd1 : 3'd0;
        end
    end

    // Next-state logic; a request is only taken while idle
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = (LAT > 0) ? WAIT : RESP;
            end
            WAIT:    if (cnt == 3'(LAT - 1)) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the request at accept; inputs are ignored at all other times
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            uns_q   <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            err_q   <= req_err;
            uns_q   <= unsigned_ld;
            idx_q   <= address[N+B-1:B];
            off_q   <= address[B-1:0];
            size_q  <= size;
            wdata_q <= write_data;
        end
    end

    // Load alignment/extension and store lane steering for the latched request
    always_comb begin
        word   = mem[idx_q];
        sh     = word >> {off_q, 3'b000};
        nbits  = 8'd8 << size_q;
        lomask = ~({W{1'b1}} << nbits);          // all ones for a full-width access
        topbit = lomask ^ (lomask >> 1);
        ext    = (!uns_q && |(sh & topbit)) ? (sh | ~lomask) : (sh & lomask);
        wsh    = wdata_q << {off_q, 3'b000};
        bmask  = ~({L{1'b1}} << (4'd1 << size_q));
        be     = bmask << off_q;
    end

    // Response and store commit, both on the edge that raises resp_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            read_data  <= '0;
            err        <= 1'b0;
            for (int i = 0; i < 2**N; i++) mem[i] <= '0;
        end else begin
            resp_valid <= (state == RESP);
            if (state == RESP) begin
                err       <= err_q;
                read_data <= (!err_q && rd_q) ? ext : '0;
                if (!err_q && wr_q) begin
                    for (int i = 0; i < L; i++)
                        if (be[i]) mem[idx_q][8*i +: 8] <= wsh[8*i +: 8];
                end
            end
        end
    end

`ifdef DATA_MEM_PERF_EN
    // Saturating per-response activity counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (state == RESP) begin
            if (err_q) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (rd_q) begin
                if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end else if (wr_q) begin
                if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: self-checking bench for data_mem_ctrl (W=32, N=8).
// It runs a vector table through a scoreboard on a LAT=1 instance. Two more
// instances, with LAT=3 and LAT=0, check throughput and latency. The bench
// also checks that a reset taken in the middle of a store aborts it.
// DATA_MEM_PERF_EN, when defined, also enables the counter checks.
module tb_data_mem_ctrl;
    localparam int W = 32, N = 8, LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, MemRead, MemWrite, unsigned_ld;
    logic [31:0] address, write_data, read_data;
    logic [1:0]  size;
    logic        resp_valid, err;

    logic        t_valid;
    logic        rdy3, resp3, err3, rdy0, resp0, err0;
    logic [31:0] rdat3, rdat0;
`ifdef DATA_MEM_PERF_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt, rc3, wc3, ec3, rc0, wc0, ec0;
`endif

    data_mem_ctrl #(.W(W), .N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address), .size(size),
        .unsigned_ld(unsigned_ld), .write_data(write_data), .resp_valid(resp_valid),
        .read_data(read_data), .err(err)
`ifdef DATA_MEM_PERF_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
`endif
    );

    data_mem_ctrl #(.W(W), .N(N), .LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(t_valid), .req_ready(rdy3),
        .MemRead(1'b1), .MemWrite(1'b0), .address(32'h0), .size(2'b10),
        .unsigned_ld(1'b0), .write_data(32'h0), .resp_valid(resp3),
        .read_data(rdat3), .err(err3)
`ifdef DATA_MEM_PERF_EN
        , .rd_cnt(rc3), .wr_cnt(wc3), .err_cnt(ec3)
`endif
    );

    data_mem_ctrl #(.W(W), .N(N), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .req_valid(t_valid), .req_ready(rdy0),
        .MemRead(1'b1), .MemWrite(1'b0), .address(32'h0), .size(2'b10),
        .unsigned_ld(1'b0), .write_data(32'h0), .resp_valid(resp0),
        .read_data(rdat0), .err(err0)
`ifdef DATA_MEM_PERF_EN
        , .rd_cnt(rc0), .wr_cnt(wc0), .err_cnt(ec0)
`endif
    );

    typedef struct {
        logic rd; logic wr; logic [31:0] addr; logic [1:0] sz; logic uns;
        logic [31:0] wd; logic [31:0] exp_d; logic exp_e;
    } vec_t;
    typedef struct { logic [31:0] d; logic e; int acc; } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0, checks = 0;
    int   cyc = 0;
    int   a3[$], r3[$], a0[$], r0[$];
    logic t_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: each response pops the oldest expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("resp_data", {32'h0, read_data}, {32'h0, mon_e.d});
                chk("resp_err", {63'h0, err}, {63'h0, mon_e.e});
                chk("resp_latency", 64'(cyc - mon_e.acc), 64'(LAT + 1));
            end
        end
    end

    // Accept/response timestamps for the LAT=3 and LAT=0 instances
    always @(negedge clk) begin
        if (t_en) begin
            if (t_valid && rdy3) a3.push_back(cyc + 1);
            if (resp3)           r3.push_back(cyc);
            if (t_valid && rdy0) a0.push_back(cyc + 1);
            if (resp0)           r0.push_back(cyc);
        end
    end

    task automatic issue(input vec_t v);
        int n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
            return;
        end
        req_valid = 1'b1; MemRead = v.rd; MemWrite = v.wr; address = v.addr;
        size = v.sz; unsigned_ld = v.uns; write_data = v.wd;
        sbq.push_back('{v.exp_d, v.exp_e, cyc + 1});
        @(negedge clk);
        // Garbage on the request bus while idle must be ignored
        req_valid = 1'b0; MemRead = 1'($urandom); MemWrite = 1'($urandom);
        address = $urandom; size = 2'($urandom); write_data = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    vec_t tv[25];
    int   nr = 0, nw = 0, ne = 0;
    logic saw;

    initial begin
        //        rd wr addr        sz     uns wdata          exp_data       exp_err
        tv[0]  = '{1, 0, 32'h40,  2'b10, 0, 32'h0,         32'h0,         0};
        tv[1]  = '{0, 1, 32'h10,  2'b10, 0, 32'h808182F3,  32'h0,         0};
        tv[2]  = '{1, 0, 32'h10,  2'b00, 0, 32'h0,         32'hFFFFFFF3,  0};
        tv[3]  = '{1, 0, 32'h13,  2'b00, 1, 32'h0,         32'h00000080,  0};
        tv[4]  = '{1, 0, 32'h12,  2'b01, 0, 32'h0,         32'hFFFF8081,  0};
        tv[5]  = '{1, 0, 32'h12,  2'b01, 1, 32'h0,         32'h00008081,  0};
        tv[6]  = '{1, 0, 32'h11,  2'b00, 0, 32'h0,         32'hFFFFFF82,  0};
        tv[7]  = '{1, 0, 32'h10,  2'b10, 1, 32'h0,         32'h808182F3,  0};
        tv[8]  = '{0, 1, 32'h20,  2'b10, 0, 32'h11223344,  32'h0,         0};
        tv[9]  = '{0, 1, 32'h22,  2'b01, 0, 32'hFFFFBEEF,  32'h0,         0};
        tv[10] = '{1, 0, 32'h20,  2'b10, 0, 32'h0,         32'hBEEF3344,  0};
        tv[11] = '{1, 0, 32'h21,  2'b01, 0, 32'h0,         32'h0,         1};
        tv[12] = '{1, 0, 32'h22,  2'b10, 0, 32'h0,         32'h0,         1};
        tv[13] = '{1, 1, 32'h20,  2'b10, 0, 32'h99999999,  32'h0,         1};
        tv[14] = '{1, 0, 32'h400, 2'b10, 0, 32'h0,         32'h0,         1};
        tv[15] = '{0, 1, 32'h400, 2'b10, 0, 32'hCAFEF00D,  32'h0,         1};
        tv[16] = '{0, 1, 32'h21,  2'b01, 0, 32'h0000AAAA,  32'h0,         1};
        tv[17] = '{1, 0, 32'h20,  2'b10, 0, 32'h0,         32'hBEEF3344,  0};
        tv[18] = '{1, 0, 32'h0,   2'b10, 0, 32'h0,         32'h0,         0};
        tv[19] = '{0, 0, 32'h20,  2'b10, 0, 32'h0,         32'h0,         0};
        tv[20] = '{1, 0, 32'h20,  2'b11, 0, 32'h0,         32'h0,         1};
        tv[21] = '{0, 1, 32'h23,  2'b00, 0, 32'h1234565A,  32'h0,         0};
        tv[22] = '{1, 0, 32'h20,  2'b10, 0, 32'h0,         32'h5AEF3344,  0};
        tv[23] = '{1, 0, 32'h20,  2'b01, 0, 32'h0,         32'h00003344,  0};
        tv[24] = '{1, 0, 32'h3FC, 2'b10, 0, 32'h0,         32'h0,         0};

        rst = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        address = '0; size = '0; unsigned_ld = 1'b0; write_data = '0; t_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        chk("rst_read_data", {32'h0, read_data}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            issue(tv[i]);
            if (tv[i].exp_e) ne++;
            else if (tv[i].rd) nr++;
            else if (tv[i].wr) nw++;
        end
        drain();
`ifdef DATA_MEM_PERF_EN
        chk("rd_cnt", {48'h0, rd_cnt}, 64'(nr));
        chk("wr_cnt", {48'h0, wr_cnt}, 64'(nw));
        chk("err_cnt", {48'h0, err_cnt}, 64'(ne));
`endif

        // Back-to-back requests on the LAT=3 and LAT=0 instances
        t_en = 1'b1; t_valid = 1'b1;
        repeat (24) @(negedge clk);
        t_valid = 1'b0;
        repeat (8) @(negedge clk);
        t_en = 1'b0;
        chk("lat3_accepts", {63'h0, a3.size() >= 4}, 64'h1);
        for (int i = 1; i < a3.size(); i++) chk("lat3_interval", 64'(a3[i] - a3[i-1]), 64'd5);
        chk("lat3_resp_count", 64'(r3.size()), 64'(a3.size()));
        for (int i = 0; i < r3.size() && i < a3.size(); i++)
            chk("lat3_latency", 64'(r3[i] - a3[i]), 64'd4);
        chk("lat0_accepts", {63'h0, a0.size() >= 8}, 64'h1);
        for (int i = 1; i < a0.size(); i++) chk("lat0_interval", 64'(a0[i] - a0[i-1]), 64'd2);
        chk("lat0_resp_count", 64'(r0.size()), 64'(a0.size()));
        for (int i = 0; i < r0.size() && i < a0.size(); i++)
            chk("lat0_latency", 64'(r0[i] - a0[i]), 64'd1);

        // Reset taken while a store waits: no response, no write
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; address = 32'h30;
        size = 2'b10; unsigned_ld = 1'b0; write_data = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        saw = resp_valid;
        repeat (2) begin @(negedge clk); saw |= resp_valid; end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); saw |= resp_valid; end
        chk("abort_no_resp", {63'h0, saw}, 64'h0);
        chk("abort_req_ready", {63'h0, req_ready}, 64'h1);
`ifdef DATA_MEM_PERF_EN
        chk("rst_rd_cnt", {48'h0, rd_cnt}, 64'h0);
        chk("rst_wr_cnt", {48'h0, wr_cnt}, 64'h0);
        chk("rst_err_cnt", {48'h0, err_cnt}, 64'h0);
`endif
        issue('{1, 0, 32'h30, 2'b10, 0, 32'h0, 32'h0, 0});
        issue('{1, 0, 32'h20, 2'b10, 0, 32'h0, 32'h0, 0});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
